// File: rtl/spmv_pkg.sv
// Shared constants and FSM encoding for the SpMV result writer.
// The result line width is derived from the lane count and lane width.
package spmv_pkg;
    localparam int DATA_W     = 16;
    localparam int LANES      = 16;
    localparam int LINE_W     = DATA_W * LANES;
    localparam int LANE_CNT_W = $clog2(LANES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } wr_state_e;
endpackage

// File: rtl/spmv_result_writer_if.sv
// Result-line stream in from the SpMV datapath and single-word M10K write port out.
// The writer uses the slave modport; the producer/memory side uses master.
interface spmv_result_writer_if #(
    parameter int ADDR_W = 10
);
    import spmv_pkg::*;

    logic              i_result_valid;
    logic [LINE_W-1:0] i_result;
    logic              o_result_ready;
    logic              o_wr_en;
    logic [ADDR_W-1:0] o_wr_addr;
    logic [DATA_W-1:0] o_wr_data;

    modport slave (
        input  i_result_valid, i_result,
        output o_result_ready, o_wr_en, o_wr_addr, o_wr_data
    );

    modport master (
        output i_result_valid, i_result,
        input  o_result_ready, o_wr_en, o_wr_addr, o_wr_data
    );
endinterface

// File: rtl/spmv_lane_serializer.sv
// Captures one result line and presents it one lane per cycle, lane 0 first.
// o_next_lane is the lane that will be current after this edge, for registered decisions upstream.
module spmv_lane_serializer
    import spmv_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_load,
    input  logic              i_advance,
    input  logic [LINE_W-1:0] i_line,
    output logic [DATA_W-1:0] o_lane,
    output logic [DATA_W-1:0] o_next_lane,
    output logic              o_last
);
    logic [LINE_W-1:0]     shreg_q, shreg_d;
    logic [LANE_CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        if (i_load) begin
            shreg_d = i_line;
            cnt_d   = '0;
        end else if (i_advance) begin
            shreg_d = {{DATA_W{1'b0}}, shreg_q[LINE_W-1:DATA_W]};
            cnt_d   = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_lane      = shreg_q[DATA_W-1:0];
    assign o_next_lane = shreg_d[DATA_W-1:0];
    assign o_last      = (cnt_q == LANE_CNT_W'(LANES - 1));
endmodule

// File: rtl/spmv_result_writer.sv
// Serializes 256-bit SpMV result lines into consecutive single-word M10K writes, one job at a time.
// Optional macro SPMV_WR_ZERO_SKIP_EN suppresses write enables for zero-valued lanes.
module spmv_result_writer
    import spmv_pkg::*;
#(
    parameter int          ADDR_W    = 10,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic [7:0] i_num_lines,
    spmv_result_writer_if.slave rif,
    output logic       o_busy,
    output logic       o_done,
    output logic [7:0] o_lines_written
);
`ifdef SPMV_WR_ZERO_SKIP_EN
    localparam bit ZERO_SKIP = 1'b1;
`else
    localparam bit ZERO_SKIP = 1'b0;
`endif

    wr_state_e         state_q, state_d;
    logic [7:0]        num_q, num_d;
    logic [7:0]        line_q, line_d;
    logic [7:0]        lw_q, lw_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              ready_q, wr_en_q, busy_q, done_q;
    logic              wr_en_d;
    logic              load, advance;
    logic [DATA_W-1:0] lane, next_lane;
    logic              last;

    spmv_lane_serializer u_ser (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_load      (load),
        .i_advance   (advance),
        .i_line      (rif.i_result),
        .o_lane      (lane),
        .o_next_lane (next_lane),
        .o_last      (last)
    );

    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        line_d  = line_q;
        lw_d    = lw_q;
        addr_d  = addr_q;
        load    = 1'b0;
        advance = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    num_d   = i_num_lines;
                    line_d  = '0;
                    lw_d    = '0;
                    state_d = (i_num_lines == 8'd0) ? DONE : WAIT;
                end
            end
            WAIT: begin
                if (rif.i_result_valid && ready_q) begin
                    load    = 1'b1;
                    // Line base address; modulo 2^ADDR_W by truncation.
                    addr_d  = ADDR_W'(BASE_ADDR + 32'(line_q) * 32'(LANES));
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (last) begin
                    line_d  = line_q + 8'd1;
                    lw_d    = lw_q + 8'd1;
                    state_d = ((line_q + 8'd1) == num_q) ? DONE : WAIT;
                end else begin
                    advance = 1'b1;
                    addr_d  = addr_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Zero lanes still consume their slot so addresses and timing stay fixed.
    always_comb begin
        wr_en_d = (state_d == SHIFT) && !(ZERO_SKIP && (next_lane == '0));
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            num_q   <= '0;
            line_q  <= '0;
            lw_q    <= '0;
            addr_q  <= '0;
            ready_q <= 1'b0;
            wr_en_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            line_q  <= line_d;
            lw_q    <= lw_d;
            addr_q  <= addr_d;
            ready_q <= (state_d == WAIT);
            wr_en_q <= wr_en_d;
            busy_q  <= (state_d != IDLE);
            done_q  <= (state_d == DONE);
        end
    end

    assign rif.o_result_ready = ready_q;
    assign rif.o_wr_en        = wr_en_q;
    assign rif.o_wr_addr      = addr_q;
    assign rif.o_wr_data      = lane;
    assign o_busy             = busy_q;
    assign o_done             = done_q;
    assign o_lines_written    = lw_q;
endmodule

// File: tb/tb_spmv_result_writer.sv
// Directed bench: two writers (base 0 and base 1020) share stimulus; expected writes are queued
// per line when it is presented and popped as o_wr_en fires.
module tb_spmv_result_writer;
    import spmv_pkg::*;

    localparam int ADDR_W = 10;
    localparam int BASE1  = 1020;
`ifdef SPMV_WR_ZERO_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    logic              clk = 1'b0;
    logic              rst, start, valid;
    logic [7:0]        num;
    logic [LINE_W-1:0] line;
    logic              busy0, busy1, done0, done1;
    logic [7:0]        lw0, lw1;

    spmv_result_writer_if #(.ADDR_W(ADDR_W)) rif0 ();
    spmv_result_writer_if #(.ADDR_W(ADDR_W)) rif1 ();

    assign rif0.i_result_valid = valid;
    assign rif0.i_result       = line;
    assign rif1.i_result_valid = valid;
    assign rif1.i_result       = line;

    spmv_result_writer #(.ADDR_W(ADDR_W), .BASE_ADDR(0)) dut0 (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_num_lines(num), .rif(rif0.slave),
        .o_busy(busy0), .o_done(done0), .o_lines_written(lw0)
    );
    spmv_result_writer #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE1)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_num_lines(num), .rif(rif1.slave),
        .o_busy(busy1), .o_done(done1), .o_lines_written(lw1)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int nacc, acc_cyc, nrdy, exp_wr, start_cyc;
    int nwr[2], first_wr[2], last_wr[2], ndone[2], done_cyc[2];
    wr_t q0[$];
    wr_t q1[$];
    logic [LINE_W-1:0] lines[4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_line(input int li, input logic [LINE_W-1:0] l);
        wr_t e;
        logic [DATA_W-1:0] v;
        for (int j = 0; j < LANES; j++) begin
            v = l[j*DATA_W +: DATA_W];
            if (SKIP && v == '0) continue;
            e.data = v;
            e.addr = ADDR_W'(li * LANES + j);
            q0.push_back(e);
            e.addr = ADDR_W'(BASE1 + li * LANES + j);
            q1.push_back(e);
            exp_wr++;
        end
    endtask

    task automatic sb(input int d, input logic en, input logic [ADDR_W-1:0] a,
                      input logic [DATA_W-1:0] dt);
        wr_t e;
        int  qs;
        if (en !== 1'b1) return;
        nwr[d]++;
        last_wr[d] = cyc;
        if (nwr[d] == 1) first_wr[d] = cyc;
        qs = (d == 0) ? q0.size() : q1.size();
        chk(d == 0 ? "wr_expected0" : "wr_expected1", 32'(qs > 0), 32'd1);
        if (qs == 0) return;
        e = (d == 0) ? q0.pop_front() : q1.pop_front();
        chk(d == 0 ? "wr_addr0" : "wr_addr1", 32'(a), 32'(e.addr));
        chk(d == 0 ? "wr_data0" : "wr_data1", 32'(dt), 32'(e.data));
    endtask

    task automatic tick();
        logic acc;
        acc = valid && rif0.o_result_ready;
        @(posedge clk);
        #1;
        cyc++;
        if (acc) begin
            if (nacc > 0) chk("line_gap", cyc - acc_cyc, 17);
            nacc++;
            acc_cyc = cyc;
        end
        if (rif0.o_result_ready) nrdy++;
        sb(0, rif0.o_wr_en, rif0.o_wr_addr, rif0.o_wr_data);
        sb(1, rif1.o_wr_en, rif1.o_wr_addr, rif1.o_wr_data);
        if (done0) begin ndone[0]++; done_cyc[0] = cyc; end
        if (done1) begin ndone[1]++; done_cyc[1] = cyc; end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_ready"}, 32'({rif0.o_result_ready, rif1.o_result_ready}), 0);
        chk({tag, "_wr_en"}, 32'({rif0.o_wr_en, rif1.o_wr_en}), 0);
        chk({tag, "_addr"},  32'({rif0.o_wr_addr, rif1.o_wr_addr}), 0);
        chk({tag, "_data"},  32'({rif0.o_wr_data, rif1.o_wr_data}), 0);
        chk({tag, "_busy"},  32'({busy0, busy1}), 0);
        chk({tag, "_done"},  32'({done0, done1}), 0);
        chk({tag, "_lw"},    32'({lw0, lw1}), 0);
    endtask

    // rst_line >= 0: assert reset while lane 7 of that line is being written.
    task automatic run_job(input int nl, input bit hold_start, input int rst_line);
        int guard;
        int li;
        nacc = 0; nrdy = 0; exp_wr = 0;
        nwr = '{0, 0}; ndone = '{0, 0};
        start = 1'b1;
        num   = 8'(nl);
        tick();
        start_cyc = cyc;
        if (hold_start) num = 8'd7;
        else start = 1'b0;
        chk("busy_after_start", 32'({busy0, busy1}), 32'b11);
        chk("ready_after_start", 32'(rif0.o_result_ready), 32'(nl != 0));
        chk("lw_cleared", 32'(lw0), 0);
        li = 0;
        if (nl > 0) begin
            push_line(0, lines[0]);
            line  = lines[0];
            valid = 1'b1;
        end
        guard = 0;
        while (ndone[0] == 0 && guard < 200) begin
            tick();
            guard++;
            if (rst_line >= 0 && nacc == rst_line + 1 && cyc == acc_cyc + 7) begin
                chk("pre_rst_wr_en", 32'(rif0.o_wr_en), 1);
                chk("pre_rst_lane7", 32'(rif0.o_wr_data), 32'(lines[rst_line][7*DATA_W +: DATA_W]));
                chk("pre_rst_lw", 32'(lw0), 32'(rst_line));
                rst   = 1'b1;
                valid = 1'b0;
                tick();
                chk_idle_outputs("mid_rst");
                q0.delete();
                q1.delete();
                return;
            end
            if (nacc > li) begin
                li++;
                if (li < nl) begin
                    push_line(li, lines[li]);
                    line = lines[li];
                end else begin
                    valid = 1'b0;
                end
            end
        end
        start = 1'b0;
        chk("done_seen0", 32'(ndone[0]), 1);
        chk("done_seen1", 32'(ndone[1]), 1);
        chk("lines_written0", 32'(lw0), 32'(nl));
        chk("lines_written1", 32'(lw1), 32'(nl));
        chk("writes0", 32'(nwr[0]), 32'(exp_wr));
        chk("writes1", 32'(nwr[1]), 32'(exp_wr));
        chk("queues_drained", 32'(q0.size() + q1.size()), 0);
        chk("ready_cycles", 32'(nrdy), 32'(nl));
        if (nl > 0) begin
            chk("last_wr_lat", 32'(last_wr[0] - acc_cyc), 15);
            chk("done_lat", 32'(done_cyc[0] - acc_cyc), 16);
            chk("done_lat1", 32'(done_cyc[1] - acc_cyc), 16);
        end else begin
            chk("zero_job_done_lat", 32'(done_cyc[0] - start_cyc), 0);
        end
        tick();
        chk("done_pulse", 32'({done0, done1}), 0);
        chk("busy_low", 32'({busy0, busy1}), 0);
        chk("lw_hold", 32'(lw0), 32'(nl));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; num = '0; valid = 1'b0; line = '0;
        nacc = 0; acc_cyc = 0; nrdy = 0; exp_wr = 0; start_cyc = 0;
        nwr = '{0, 0}; first_wr = '{0, 0}; last_wr = '{0, 0};
        ndone = '{0, 0}; done_cyc = '{0, 0};
        tick();
        tick();
        chk_idle_outputs("reset");
        rst = 1'b0;
        tick();

        // Single line, lanes 0x0001..0x0010; dut1 also exercises address wrap.
        for (int j = 0; j < LANES; j++) lines[0][j*DATA_W +: DATA_W] = 16'(j + 1);
        run_job(1, 1'b0, -1);
        chk("first_wr_lat", 32'(first_wr[0] - acc_cyc), 0);
        for (int k = 0; k < 3; k++) tick();
        chk("lw_idle_hold", 32'(lw0), 1);

        // Three lines, valid held high, stray start with a new count held during the job.
        for (int j = 0; j < LANES; j++) begin
            lines[0][j*DATA_W +: DATA_W] = 16'h0100 + 16'(j + 1);
            lines[1][j*DATA_W +: DATA_W] = (j == 2 || j == 9) ? 16'h0000 : 16'hA000 + 16'(j);
            lines[2][j*DATA_W +: DATA_W] = 16'($urandom_range(1, 16'hFFFF));
        end
        run_job(3, 1'b1, -1);

        // Zero-line job: done straight after start, no writes.
        run_job(0, 1'b0, -1);
        chk("zero_job_no_wr", 32'(nwr[0] + nwr[1]), 0);

        // Reset during lane 7 of the second line, then a fresh job from the base address.
        run_job(2, 1'b0, 1);
        tick();
        chk("rst_held_idle", 32'({busy0, lw0}), 0);
        rst = 1'b0;
        tick();
        for (int j = 0; j < LANES; j++) lines[0][j*DATA_W +: DATA_W] = 16'h5500 + 16'(j * 3 + 1);
        run_job(1, 1'b0, -1);
        chk("post_rst_first_wr", 32'(first_wr[0] - acc_cyc), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/spmv_result_writer.md
# spmv_result_writer

Write-side counterpart to the SpMV read path: accepts 256-bit result lines (16 lanes × 16-bit) from the SpMV datapath over a valid/ready handshake. Each line is serialized into 16 single-word M10K write transactions at consecutive addresses. A job writes a programmed number of lines starting at a base address, then pulses done. It sits between the SpMV result output and the result M10K bank's write port.

## Interface
- DATA_W, 16, lane/word width in bits
- LANES, 16, lanes per result line (line width = DATA_W*LANES = 256)
- ADDR_W, 10, M10K word-address width
- BASE_ADDR, 0, word address of lane 0 of line 0
- Clocking and reset (already decided): one clock; reset is asynchronous and active-high.
- i_clk  in  1  clock, all state on rising edge
- i_rst  in  1  asynchronous active-high reset
- i_start  in  1  start a job; sampled only in IDLE
- i_num_lines  in  8  lines in the job; latched on accepted i_start
- i_result_valid  in  1  i_result holds a valid line
- i_result  in  256  result line; lane j = i_result[j*16 +: 16]
- o_result_ready  out  1  writer can accept a line this cycle
- o_wr_en  out  1  M10K write enable
- o_wr_addr  out  ADDR_W  M10K word address
- o_wr_data  out  16  M10K write data
- o_busy  out  1  job in progress (not IDLE)
- o_done  out  1  one-cycle pulse at job end
- o_lines_written  out  8  lines fully written in current/last job

## Operation
- FSM states: IDLE, WAIT, SHIFT, DONE.
- IDLE: i_start=1 -> latch i_num_lines, clear line/lane counters and o_lines_written; if i_num_lines==0 go DONE, else WAIT.
- WAIT: o_result_ready=1. Transfer on i_result_valid && o_result_ready; line captured into shift register, lane counter=0, go SHIFT. Valid without ready is held by upstream (no drop).
- SHIFT: one write per cycle, lanes 0..15 in order; o_wr_data = lane[lane_cnt], o_wr_addr = BASE_ADDR + line_cnt*LANES + lane_cnt, modulo 2^ADDR_W (wraps silently). After lane 15: line_cnt and o_lines_written increment; if line_cnt+1 == num_lines go DONE, else WAIT.
- DONE: o_done=1 for exactly one cycle, then IDLE. o_lines_written holds until next accepted i_start.
- i_start outside IDLE is ignored; i_num_lines changes after latch have no effect.
- o_result_ready is 0 in IDLE, SHIFT, DONE.
- Reset (any time, including mid-line): state IDLE, all counters 0, shift register 0; no partial write completes after reset asserts.

## Timing
- Reset values: o_result_ready=0, o_wr_en=0, o_wr_addr=0, o_wr_data=0, o_busy=0, o_done=0, o_lines_written=0.
- All outputs registered.
- Start accepted at edge k -> o_busy=1 and o_result_ready=1 from cycle k+1.
- Line accepted at edge t -> lane j written in cycle t+1+j (o_wr_en high cycles t+1..t+16).
- Next line acceptable at edge t+17 at earliest: throughput 17 cycles/line.
- Last lane write in cycle t+16 -> o_done high in cycle t+17, o_busy low from t+18.
- i_num_lines==0: start at edge k -> o_done in cycle k+1, no writes.

## Configuration
- SPMV_WR_ZERO_SKIP_EN defined: a lane whose value is 0 drives o_wr_en=0 in its slot; address/lane counters and timing unchanged (destination assumed pre-cleared).
- Undefined: all 16 lanes written every line regardless of value.

## Structure
- Shared package spmv_pkg: DATA_W, LANES, line width constant, FSM state typedef (IDLE/WAIT/SHIFT/DONE).
- One sub-module: spmv_lane_serializer — 256-bit capture/shift register plus 4-bit lane counter, outputs current lane and last-lane flag; top holds FSM, line counter, address generation.

## Test plan
- Reset values: assert i_rst mid-simulation -> all outputs 0 next cycle, state IDLE.
- Single line: num_lines=1, i_result lanes = 0x0001..0x0010 -> 16 writes, addr 0..15, data 0x0001..0x0010 on consecutive cycles; o_done 17 cycles after accept; o_lines_written=1.
- Multi-line with backpressure: num_lines=3, valid asserted continuously -> ready high only in WAIT; 48 writes to addr 0..47; lines accepted 17 cycles apart.
- Wrap and zero-job: BASE_ADDR=1020, num_lines=1 -> addresses 1020..1023, 0..11; num_lines=0 -> o_done one cycle after start, no o_wr_en.
- Reset mid-line: i_rst during lane 7 -> o_wr_en low next cycle; new job after release writes from BASE_ADDR, o_lines_written restarts at 0.
- Zero skip (macro on): lanes 2 and 9 zero -> o_wr_en low in those slots, addresses still advance; macro off -> 16 writes including zeros.
